// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, requester IDs, defaults.
// Build option DMEM_ARB_RR_EN (see dmem_arb_pick) does not change anything here.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int STARVE_LIM_DEF = 4;
  localparam int WAIT_W         = 4;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the memory issue slot; zero latency, no state.
// Default: CPU priority unless DMA wait count hit STARVE_LIM. DMEM_ARB_RR_EN: alternate on contention.
import dmem_arb_pkg::*;

module dmem_arb_pick #(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              cpu_req,
  input  logic              dma_req,
  input  logic [WAIT_W-1:0] wait_cnt,
  input  logic              last_gnt,
  output logic              gnt_cpu,
  output logic              gnt_dma
);

  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(STARVE_LIM);

  logic dma_wins_tie;
  logic unused_pick;

`ifdef DMEM_ARB_RR_EN
  // Whoever was not served last wins a simultaneous request.
  assign dma_wins_tie = (last_gnt == REQ_CPU);
  assign unused_pick  = (wait_cnt == LIM);
`else
  // DMA only overtakes the CPU once it has waited STARVE_LIM issue cycles.
  assign dma_wins_tie = (wait_cnt == LIM);
  assign unused_pick  = last_gnt;
`endif

  always_comb begin
    gnt_dma = dma_req && (!cpu_req || dma_wins_tie);
    gnt_cpu = cpu_req && !gnt_dma;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises CPU MEM-stage and DMA accesses onto one sync-read memory port (option DMEM_ARB_RR_EN).
// Latency: writes issue same cycle; reads return one cycle later (CPU stalled for that cycle).
// Backpressure: cpu_stall freezes the pipeline; DMA holds its request until the dma_gnt pulse.
import dmem_arb_pkg::*;

module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(STARVE_LIM);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              last_gnt_q, last_gnt_d;

  logic gnt_cpu;
  logic gnt_dma;
  logic in_idle;

  assign in_idle = (state_q == IDLE);

  dmem_arb_pick #(
    .STARVE_LIM (STARVE_LIM)
  ) u_pick (
    .cpu_req  (cpu_req && in_idle),
    .dma_req  (dma_req && in_idle),
    .wait_cnt (wait_cnt_q),
    .last_gnt (last_gnt_q),
    .gnt_cpu  (gnt_cpu),
    .gnt_dma  (gnt_dma)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    last_gnt_d = last_gnt_q;
    cpu_rdata  = '0;
    cpu_stall  = 1'b0;
    dma_gnt    = 1'b0;
    dma_rvalid = 1'b0;
    dma_rdata  = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (gnt_cpu) begin
          mem_en     = 1'b1;
          mem_wr     = cpu_wr;
          mem_addr   = cpu_addr;
          mem_wdata  = cpu_wdata;
          last_gnt_d = REQ_CPU;
          if (!cpu_wr) begin
            state_d = CPU_RD;
          end
        end else if (gnt_dma) begin
          mem_en     = 1'b1;
          mem_wr     = dma_wr;
          mem_addr   = dma_addr;
          mem_wdata  = dma_wdata;
          dma_gnt    = 1'b1;
          last_gnt_d = REQ_DMA;
          if (!dma_wr) begin
            state_d = DMA_RD;
          end
        end

        if (gnt_dma) begin
          wait_cnt_d = '0;
        end else if (dma_req && (wait_cnt_q < LIM)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end

        // A store completes in the issue cycle; anything else holds the pipeline.
        cpu_stall = cpu_req && !(gnt_cpu && cpu_wr);
      end

      CPU_RD: begin
        cpu_rdata = mem_rdata;
        state_d   = IDLE;
      end

      DMA_RD: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_rdata;
        cpu_stall  = cpu_req;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet for the whole time reset is held.
    if (!rst) begin
      cpu_rdata  = '0;
      cpu_stall  = 1'b0;
      dma_gnt    = 1'b0;
      dma_rvalid = 1'b0;
      dma_rdata  = '0;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      last_gnt_q <= REQ_CPU;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule
